// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with runtime CPOL/CPHA,
// selectable bit order, indexed chip selects and a start/busy/done handshake.
// spi_clk is an ordinary registered output; everything runs on clk.
module spi_master_param #(
    parameter int DATA_W      = 8,
    parameter int HALF_PERIOD = 2,
    parameter int NUM_CS      = 1,
    parameter int CS_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int CNT_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;          // clk cycles within the current half period
    logic [EDGE_W-1:0]  edge_cnt;     // spi_clk edges already produced
    logic               sample;       // high in a cycle whose end captures miso
    logic               cpha_q;
    logic               lsb_q;
    logic [DATA_W-1:0]  tx_sh;        // bits still to be presented, next one at the front
    logic [DATA_W-1:0]  rx_sh;

    logic               accept;
    logic               tick;
    logic               do_edge;
    logic               lead_edge;
    logic               last_edge;
    logic               adv_mosi;
    logic               take_sample;

    // Bit at the front of a word for the chosen order.
    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Drop the front bit so the following bit moves to the front.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Insert a received bit; LSB-first data enters at the top so the
    // first received bit ends at bit 0 and the word keeps natural order.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                    input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // One-hot-low chip select; an index with no matching line selects nothing.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int j = 0; j < NUM_CS; j++) begin
            if (sel == CS_W'(j)) v[j] = 1'b0;
        end
        return v;
    endfunction

    assign busy        = (state != IDLE);
    assign accept      = start && (state == IDLE);
    assign tick        = (state != IDLE) && (cnt == CNT_W'(HALF_PERIOD - 1));
    assign do_edge     = tick && ((state == LEAD) || (state == SHIFT));
    // Edge number edge_cnt+1 is about to be produced; odd numbers are leading.
    assign lead_edge   = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
    // cpha=1 presents on leading edges; cpha=0 advances on trailing edges
    // except the final one, since its first bit went out at accept.
    assign adv_mosi    = cpha_q ? lead_edge : (~lead_edge && ~last_edge);
    assign take_sample = cpha_q ? ~lead_edge : lead_edge;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; every state after IDLE lasts whole half periods.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)             state_nxt = LEAD;
            LEAD:    if (tick)               state_nxt = SHIFT;
            SHIFT:   if (tick && last_edge)  state_nxt = TRAIL;
            TRAIL:   if (tick)               state_nxt = GAP;
            GAP:     if (tick)               state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Pacing counters, serial clock, chip selects, mosi and the done handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            edge_cnt <= '0;
            sample   <= 1'b0;
            spi_clk  <= 1'b0;
            cs_n     <= '1;
            mosi     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done   <= 1'b0;
            sample <= 1'b0;
            if (accept || tick) cnt <= '0;
            else if (busy)      cnt <= cnt + 1'b1;
            if (state == IDLE) begin
                spi_clk <= cpol;
                if (accept) begin
                    edge_cnt <= '0;
                    cs_n     <= cs_decode(cs_sel);
                    if (!cpha) mosi <= first_bit(tx_data, lsb_first);
                end
            end
            if (do_edge) begin
                spi_clk  <= ~spi_clk;
                edge_cnt <= edge_cnt + 1'b1;
                sample   <= take_sample;
                if (adv_mosi) mosi <= first_bit(tx_sh, lsb_q);
            end
            if (tick && (state == TRAIL)) cs_n <= '1;
            if (tick && (state == GAP)) begin
                done    <= 1'b1;
                rx_data <= rx_sh;
            end
        end
    end

    // Transfer settings and shift registers, captured at accept and walked per edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            tx_sh  <= cpha ? tx_data : shift_word(tx_data, lsb_first);
        end else if (do_edge && adv_mosi) begin
            tx_sh  <= shift_word(tx_sh, lsb_q);
        end
        if (sample) rx_sh <= shift_in(rx_sh, miso, lsb_q);
    end

endmodule
